note_sequencer: RTL and testbench
=================================

# note_sequencer

Plays a song held in an external note ROM by driving a tone generator, and runs alongside the speaker/LED datapath in the music processor. It fetches note entries one at a time and times each note and inter-note gap in milliseconds from the `ticks_per_milli` clock scale. It drives the tone-enable and note-select inputs of the tone generator, plus an LED status byte. It supports single-shot or looped playback under a level-sensitive `play` control.

## Interface
- `SONG_LEN`, 16: number of ROM entries; the address wraps or ends at this count (power of two, 2..256).
- `DUR_UNIT_MS`, 50: milliseconds per duration step.
- `GAP_MS`, 20: silent gap after every entry, in ms; 0 means no gap state.
- `clk` input 1: system clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `ticks_per_milli` input 16: clock cycles per millisecond; 0 is treated as 1.
- `play` input 1: level; 1 = run, 0 = abort to IDLE.
- `loop` input 1: at end of song, restart from address 0 instead of finishing.
- `rom_addr` output log2(SONG_LEN): registered ROM address.
- `rom_data` input 8: combinational ROM read of `rom_addr`. Bits [7:3] are the note (0 = rest); bits [2:0] are the duration code.
- `tone_en` output 1: enables the tone generator.
- `tone_note` output 5: note index to the tone generator.
- `busy` output 1: high in any state other than IDLE.
- `done` output 1: one-cycle pulse on normal song completion.
- `led` output 8: {tone_en, 2'b00, tone_note}.

## Operation
- States:
  - IDLE: `rom_addr`=0, `tone_en`=0. If `play`=1, go to FETCH.
  - FETCH: one cycle. Sample `rom_data`.
    - End condition: `rom_data`==8'h00.
      - `loop`=1: `rom_addr`←0, stay in FETCH.
      - `loop`=0: go to DONE.
    - Otherwise: latch note into `tone_note`, `ms_left`←(dur+1)*DUR_UNIT_MS, go to PLAY.
  - PLAY: `tone_en` = (`tone_note`≠0); a rest stays silent but is timed identically. When `ms_left` expires:
    - GAP_MS>0: `ms_left`←GAP_MS, go to GAP.
    - GAP_MS=0: go to ADVANCE.
  - GAP: `tone_en`=0. When `ms_left` expires, go to ADVANCE.
  - ADVANCE: one cycle, folded into the expiry edge, not a separate state.
    - `rom_addr`=SONG_LEN-1 and `loop`=0: go to DONE.
    - `rom_addr`=SONG_LEN-1 and `loop`=1: `rom_addr`←0, go to FETCH.
    - Otherwise: `rom_addr`+1, go to FETCH.
  - DONE: `done`=1 for one cycle, then go to IDLE. `play` must return to 0 and back to 1 to replay; while in IDLE after DONE, `play` must have been sampled low at least once before restarting.
- Millisecond timer:
  - `tick_cnt` (16 bit) counts 0..T-1, where T = max(`ticks_per_milli`,1). On wrap, `ms_left` decrements.
  - Expiry is the wrap cycle on which `ms_left`==1.
  - `tick_cnt` clears on entry to PLAY and to GAP.
- `ms_left` is 16 bit. Products are computed without truncation for legal parameters.
- `ticks_per_milli` is sampled continuously. A change mid-note takes effect at the next comparison; no glitch protection.
- `play`=0 in any state: next cycle IDLE, `tone_en`=0, `rom_addr`=0, counters cleared, no `done` pulse. This has priority over every other transition.
- Reset values: state IDLE, `rom_addr`=0, `tone_en`=0, `tone_note`=0, `busy`=0, `done`=0, `led`=0, counters 0. Reset mid-note silences `tone_en` immediately (asynchronously).

## Timing
- `play` rises and is sampled at edge k: FETCH during cycle k+1, `tone_en`=1 from edge k+2.
- `tone_en` is high for exactly dur_ms*T cycles.
- Gap lasts GAP_MS*T cycles.
- Next FETCH is one cycle, so entry-to-entry period = (dur_ms+GAP_MS)*T+1 cycles.
- `done` asserts on the cycle after the terminating FETCH or ADVANCE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
Test parameters: SONG_LEN=4, DUR_UNIT_MS=2, GAP_MS=1, `ticks_per_milli`=10.
- Single note: ROM {8'h29, 8'h00, …}, `play`=1, `loop`=0.
  - `tone_note`=5 and `tone_en` high for exactly 40 cycles, starting 2 cycles after `play`.
  - Then 10 silent cycles, one FETCH, `done` pulse, then IDLE.
- Rest entry: ROM {8'h01, 8'h31, 8'h00}.
  - First 40 cycles: `tone_en`=0 with `tone_note`=0 and `busy`=1.
  - Then note 6 plays for 40 cycles.
- Full-length wrap: 4 non-zero entries, `loop`=1.
  - After address 3, `rom_addr` returns to 0 and the first note repeats.
  - Never a `done` pulse.
- Abort: drop `play` 15 cycles into a note.
  - Next cycle: `tone_en`=0, `rom_addr`=0, `busy`=0, no `done`.
  - Re-raising `play` restarts at entry 0.
- `ticks_per_milli`=0 with ROM {8'h28}: note lasts 2 cycles (T=1).
- Async reset: assert `rst_n`=0 mid-PLAY.
  - `tone_en`, `led`, `busy` go to 0 without waiting for a clock edge.
  - After release, the block stays in IDLE until `play` is sampled.

Source files
------------

// File: rtl/note_sequencer.sv
// note_sequencer: steps a note ROM and drives a tone generator.
// Ports: clk, rst_n, ticks_per_milli, play, loop, rom_addr/rom_data,
//        tone_en, tone_note, busy, done, led.
module note_sequencer #(
  parameter int SONG_LEN    = 16,
  parameter int DUR_UNIT_MS = 50,
  parameter int GAP_MS      = 20,
  localparam int AW = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [15:0]   ticks_per_milli,
  input  logic          play,
  input  logic          loop,
  output logic [AW-1:0] rom_addr,
  input  logic [7:0]    rom_data,
  output logic          tone_en,
  output logic [4:0]    tone_note,
  output logic          busy,
  output logic          done,
  output logic [7:0]    led
);

  localparam logic [AW-1:0] LAST = AW'(SONG_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_t;

  state_t state, state_d;

  logic [15:0] tick_cnt;
  logic [15:0] ms_left;
  logic [15:0] t_last;
  logic [15:0] ms_dur;
  logic        need_low;
  logic        wrap;
  logic        expire;
  logic        end_entry;
  logic        at_last;
  logic        timing;

  // 0 ticks/ms behaves as 1, so the last tick index is 0.
  assign t_last = (ticks_per_milli == 16'd0) ? 16'd0
                : ticks_per_milli - 16'd1;
  // >= keeps the count sane if the scale shrinks mid-note.
  assign wrap      = tick_cnt >= t_last;
  assign expire    = wrap && (ms_left <= 16'd1);
  assign end_entry = rom_data == 8'h00;
  assign at_last   = rom_addr == LAST;
  assign timing    = (state == S_PLAY) || (state == S_GAP);
  assign ms_dur    = ({13'd0, rom_data[2:0]} + 16'd1)
                   * 16'(DUR_UNIT_MS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (!play) begin
      state_d = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:  if (!need_low) state_d = S_FETCH;
        S_FETCH: begin
          if (end_entry) state_d = loop ? S_FETCH : S_DONE;
          else           state_d = S_PLAY;
        end
        S_PLAY: begin
          if (expire) begin
            if (GAP_MS > 0)          state_d = S_GAP;
            else if (at_last && !loop) state_d = S_DONE;
            else                     state_d = S_FETCH;
          end
        end
        S_GAP: begin
          if (expire) begin
            if (at_last && !loop) state_d = S_DONE;
            else                  state_d = S_FETCH;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    tone_en = (state == S_PLAY) && (tone_note != 5'd0);
    busy    = state != S_IDLE;
    done    = state == S_DONE;
    led     = {tone_en, 2'b00, tone_note};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr  <= '0;
      tone_note <= '0;
      tick_cnt  <= '0;
      ms_left   <= '0;
      need_low  <= 1'b0;
    end else if (!play) begin
      rom_addr  <= '0;
      tone_note <= '0;
      tick_cnt  <= '0;
      ms_left   <= '0;
      need_low  <= 1'b0;
    end else begin
      // Block a replay until play has been seen low again.
      if (state == S_DONE) need_low <= 1'b1;
      if (state == S_FETCH) begin
        if (end_entry) begin
          if (loop) rom_addr <= '0;
        end else begin
          tone_note <= rom_data[7:3];
          ms_left   <= ms_dur;
          tick_cnt  <= '0;
        end
      end
      if (timing) begin
        if (wrap) begin
          tick_cnt <= '0;
          ms_left  <= ms_left - 16'd1;
        end else begin
          tick_cnt <= tick_cnt + 16'd1;
        end
        if (expire) begin
          if (state == S_PLAY && GAP_MS > 0) begin
            ms_left <= 16'(GAP_MS);
          end else begin
            rom_addr <= at_last ? '0 : rom_addr + AW'(1);
          end
        end
      end
      if (state == S_DONE) begin
        rom_addr  <= '0;
        tone_note <= '0;
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed checks of note_sequencer.
// SONG_LEN=4, DUR_UNIT_MS=2, GAP_MS=1, ticks_per_milli=10.
module tb_note_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] tpm;
  logic        play;
  logic        loop_i;
  logic [1:0]  rom_addr;
  logic [7:0]  rom_data;
  logic        tone_en;
  logic [4:0]  tone_note;
  logic        busy;
  logic        done;
  logic [7:0]  led;

  logic [7:0] rom [0:3];
  assign rom_data = rom[rom_addr];

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int base;
  int c;

  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  note_sequencer #(
    .SONG_LEN(4),
    .DUR_UNIT_MS(2),
    .GAP_MS(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ticks_per_milli(tpm),
    .play(play),
    .loop(loop_i),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .tone_en(tone_en),
    .tone_note(tone_note),
    .busy(busy),
    .done(done),
    .led(led)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    play   = 1'b0;
    loop_i = 1'b0;
    tpm    = 16'd10;
    rom    = '{8'h00, 8'h00, 8'h00, 8'h00};
    step(3);
    check("rst_busy", busy, 0);
    check("rst_tone_en", tone_en, 0);
    check("rst_led", led, 0);
    check("rst_done", done, 0);
    check("rst_addr", rom_addr, 0);
    check("rst_note", tone_note, 0);
    rst_n = 1'b1;
    step(2);

    // single note then done
    rom  = '{8'h29, 8'h00, 8'h00, 8'h00};
    base = done_cnt;
    play = 1'b1;
    c = 0;
    do begin step(); c++; end while (!tone_en && c < 20);
    check("t1_start", c, 2);
    check("t1_note", tone_note, 5);
    check("t1_led", led, 8'h85);
    c = 0;
    while (tone_en && c < 200) begin c++; step(); end
    check("t1_len", c, 40);
    c = 1;
    while (!done && c < 50) begin step(); c++; end
    check("t1_done_at", c, 12);
    step();
    check("t1_idle_busy", busy, 0);
    check("t1_done_once", done_cnt - base, 1);
    step(3);
    check("t1_noreplay", busy, 0);
    play = 1'b0;
    step(2);

    // rest entry then note 6
    rom  = '{8'h01, 8'h31, 8'h00, 8'h00};
    play = 1'b1;
    step(2);
    check("t2_rest_busy", busy, 1);
    check("t2_rest_en", tone_en, 0);
    check("t2_rest_note", tone_note, 0);
    c = 0;
    while (!tone_en && c < 200) begin c++; step(); end
    check("t2_silent", c, 51);
    check("t2_note", tone_note, 6);
    check("t2_addr", rom_addr, 1);
    c = 0;
    while (tone_en && c < 200) begin c++; step(); end
    check("t2_len", c, 40);
    play = 1'b0;
    step(2);

    // looped playback wraps
    rom    = '{8'h29, 8'h31, 8'h39, 8'h41};
    loop_i = 1'b1;
    base   = done_cnt;
    play   = 1'b1;
    c = 0;
    while (rom_addr != 2'd3 && c < 500) begin step(); c++; end
    check("t3_reach3", rom_addr, 3);
    while (rom_addr != 2'd0 && c < 500) begin step(); c++; end
    check("t3_wrap", rom_addr, 0);
    check("t3_busy", busy, 1);
    check("t3_fetch_en", tone_en, 0);
    c = 0;
    while (!tone_en && c < 20) begin step(); c++; end
    check("t3_refetch", c, 1);
    check("t3_note", tone_note, 5);
    check("t3_nodone", done_cnt - base, 0);
    play   = 1'b0;
    loop_i = 1'b0;
    step(2);

    // abort mid-note
    rom  = '{8'h29, 8'h31, 8'h00, 8'h00};
    base = done_cnt;
    play = 1'b1;
    c = 0;
    while (!(tone_en && tone_note == 5'd6) && c < 300) begin
      step(); c++;
    end
    check("t4_second", tone_note, 6);
    step(14);
    play = 1'b0;
    step();
    check("t4_en", tone_en, 0);
    check("t4_addr", rom_addr, 0);
    check("t4_busy", busy, 0);
    check("t4_led", led, 0);
    step(2);
    check("t4_nodone", done_cnt - base, 0);
    play = 1'b1;
    step(2);
    check("t4_restart_en", tone_en, 1);
    check("t4_restart_note", tone_note, 5);
    check("t4_restart_addr", rom_addr, 0);
    play = 1'b0;
    step(2);

    // zero ticks per ms acts as one
    tpm  = 16'd0;
    rom  = '{8'h28, 8'h00, 8'h00, 8'h00};
    play = 1'b1;
    c = 0;
    do begin step(); c++; end while (!tone_en && c < 20);
    check("t5_start", c, 2);
    check("t5_note", tone_note, 5);
    c = 0;
    while (tone_en && c < 50) begin c++; step(); end
    check("t5_len", c, 2);
    play = 1'b0;
    tpm  = 16'd10;
    step(2);

    // asynchronous reset mid-note
    rom  = '{8'h29, 8'h00, 8'h00, 8'h00};
    play = 1'b1;
    step(7);
    check("t6_pre_en", tone_en, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_en", tone_en, 0);
    check("t6_async_led", led, 0);
    check("t6_async_busy", busy, 0);
    play = 1'b0;
    step(2);
    #2 rst_n = 1'b1;
    step(3);
    check("t6_idle", busy, 0);
    play = 1'b1;
    step(2);
    check("t6_replay_en", tone_en, 1);
    check("t6_replay_note", tone_note, 5);
    play = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
